// File: rtl/cpu_core.sv
// cpu_core: multi-cycle 16-bit bus-based processor with eight general
// registers, an ALU input register A and a result register G.
// Instructions (mv, mvi, add, sub, NOP) are fetched from din on a run
// strobe. Every datapath transfer goes over one internal bus.
module cpu_core #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              run,
  input  logic [DATA_W-1:0] din,
  output logic              done,
  output logic [DATA_W-1:0] bus,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] r2,
  output logic [DATA_W-1:0] r3,
  output logic [DATA_W-1:0] r4,
  output logic [DATA_W-1:0] r5,
  output logic [DATA_W-1:0] r6,
  output logic [DATA_W-1:0] r7
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  state_t            state;
  logic [8:0]        ir;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] alu_out;

  logic [2:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[8:6];
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  assign r0 = regs[0];
  assign r1 = regs[1];
  assign r2 = regs[2];
  assign r3 = regs[3];
  assign r4 = regs[4];
  assign r5 = regs[5];
  assign r6 = regs[6];
  assign r7 = regs[7];

  // add and sub take the three-cycle A/G path; everything else ends in T1
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // Bus source selection: one driver per state, zero when idle or on NOP
  always_comb begin
    bus = '0;
    case (state)
      T1: begin
        case (opcode)
          OP_MV:          bus = regs[ry];
          OP_MVI:         bus = din;
          OP_ADD, OP_SUB: bus = regs[rx];
          default:        bus = '0;
        endcase
      end
      T2:      bus = regs[ry];
      T3:      bus = g;
      default: bus = '0;
    endcase
  end

  // ALU: A combined with the bus, wrapping silently modulo 2^DATA_W
  always_comb begin
    alu_out = a + bus;
    if (opcode == OP_SUB) begin
      alu_out = a - bus;
    end
  end

  // Control FSM with a registered done that is high during the final cycle
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= T0;
      ir    <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        T0: begin
          if (run) begin
            ir    <= din[8:0];
            state <= T1;
            done  <= !is_alu_op(din[8:6]);
          end
        end
        T1: begin
          if (is_alu_op(opcode)) begin
            state <= T2;
          end else begin
            state <= T0;
          end
        end
        T2: begin
          state <= T3;
          done  <= 1'b1;
        end
        default: begin
          state <= T0;
        end
      endcase
    end
  end

  // Register file, A and G: at most one of them captures the bus per edge
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
      a <= '0;
      g <= '0;
    end else begin
      case (state)
        T1: begin
          if (opcode == OP_MV || opcode == OP_MVI) begin
            regs[rx] <= bus;
          end else if (is_alu_op(opcode)) begin
            a <= bus;
          end
        end
        T2: begin
          g <= alu_out;
        end
        T3: begin
          regs[rx] <= bus;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed self-checking bench for cpu_core. Each instruction
// is issued on a run strobe and its done latency, bus value in the final
// cycle and the resulting register file are compared against expectations.
module tb_cpu_core;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_NOP = 3'b111;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] din = '0;
  logic        done;
  logic [15:0] bus;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
  logic [15:0] obs [8];
  logic [15:0] model [8];

  int test_count = 0;
  int fail_count = 0;

  cpu_core #(.DATA_W(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .run    (run),
    .din    (din),
    .done   (done),
    .bus    (bus),
    .r0     (r0),
    .r1     (r1),
    .r2     (r2),
    .r3     (r3),
    .r4     (r4),
    .r5     (r5),
    .r6     (r6),
    .r7     (r7)
  );

  assign obs[0] = r0;
  assign obs[1] = r1;
  assign obs[2] = r2;
  assign obs[3] = r3;
  assign obs[4] = r4;
  assign obs[5] = r5;
  assign obs[6] = r6;
  assign obs[7] = r7;

  // Free-running clock, period 10
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic checkRegs(input string tag);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s r%0d", tag, i), {16'h0, obs[i]}, {16'h0, model[i]});
    end
  endtask

  // Issue one instruction, follow it to done and update the reference model
  task automatic applyStimulus(input logic [2:0] op, input logic [2:0] rx,
                               input logic [2:0] ry, input logic [15:0] imm,
                               input int exp_lat, input string tag);
    int          lat;
    logic [15:0] result;
    logic [15:0] exp_bus;
    lat = 0;
    case (op)
      OP_MV:   begin result = model[ry];            exp_bus = result; end
      OP_MVI:  begin result = imm;                  exp_bus = result; end
      OP_ADD:  begin result = model[rx] + model[ry]; exp_bus = result; end
      OP_SUB:  begin result = model[rx] - model[ry]; exp_bus = result; end
      default: begin result = model[rx];            exp_bus = 16'h0;  end
    endcase
    @(negedge clock);
    run = 1'b1;
    din = {7'h0, op, rx, ry};
    @(posedge clock);
    #1;
    run = 1'b0;
    din = imm;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (done) begin
        lat = c;
        break;
      end
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " bus"}, {16'h0, bus}, {16'h0, exp_bus});
    @(posedge clock);
    #1;
    din = '0;
    if (op[2] == 1'b0) begin
      model[rx] = result;
    end
    @(negedge clock);
    checkOutput({tag, " done low"}, {31'h0, done}, 32'h0);
    checkOutput({tag, " idle bus"}, {16'h0, bus}, 32'h0);
    checkRegs(tag);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // Reset state
    resetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset done", {31'h0, done}, 32'h0);
    checkOutput("reset bus", {16'h0, bus}, 32'h0);
    checkRegs("reset");
    resetn = 1'b1;

    // Initialise Ri = i
    for (int i = 0; i < 8; i++) begin
      applyStimulus(OP_MVI, 3'(i), 3'd0, 16'(i), 1, $sformatf("init mvi r%0d", i));
    end
    checkOutput("init r7", {16'h0, r7}, 32'd7);

    // add sweep over every Rx/Ry pair, restoring Rx after each
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        applyStimulus(OP_ADD, 3'(x), 3'(y), 16'h0, 3, $sformatf("add r%0d,r%0d", x, y));
        checkOutput($sformatf("add r%0d,r%0d sum", x, y), {16'h0, obs[x]}, 32'(x + y));
        applyStimulus(OP_MVI, 3'(x), 3'd0, 16'(x), 1, $sformatf("reinit r%0d", x));
      end
    end

    // Self-operand cases
    applyStimulus(OP_ADD, 3'd5, 3'd5, 16'h0, 3, "add r5,r5");
    checkOutput("double r5", {16'h0, r5}, 32'd10);
    applyStimulus(OP_SUB, 3'd5, 3'd5, 16'h0, 3, "sub r5,r5");
    checkOutput("zero r5", {16'h0, r5}, 32'd0);

    // Wrap-around in both directions
    applyStimulus(OP_MVI, 3'd0, 3'd0, 16'hFFFF, 1, "mvi r0,ffff");
    applyStimulus(OP_MVI, 3'd1, 3'd0, 16'h0001, 1, "mvi r1,1");
    applyStimulus(OP_ADD, 3'd0, 3'd1, 16'h0, 3, "add wrap");
    checkOutput("wrap add r0", {16'h0, r0}, 32'h0000);
    applyStimulus(OP_SUB, 3'd0, 3'd1, 16'h0, 3, "sub wrap");
    checkOutput("wrap sub r0", {16'h0, r0}, 32'hFFFF);

    // Plain sub with distinct operands: 7 - 2
    applyStimulus(OP_SUB, 3'd7, 3'd2, 16'h0, 3, "sub r7,r2");
    checkOutput("sub r7", {16'h0, r7}, 32'd5);
    applyStimulus(OP_MVI, 3'd7, 3'd0, 16'd7, 1, "reinit r7");

    // mv and NOP
    applyStimulus(OP_MV, 3'd3, 3'd7, 16'h0, 1, "mv r3,r7");
    checkOutput("mv r3", {16'h0, r3}, 32'd7);
    applyStimulus(OP_MV, 3'd4, 3'd4, 16'h0, 1, "mv r4,r4");
    checkOutput("mv r4 self", {16'h0, r4}, 32'd4);
    applyStimulus(OP_NOP, 3'd2, 3'd5, 16'h1234, 1, "nop");
    applyStimulus(3'b100, 3'd6, 3'd1, 16'hABCD, 1, "nop100");

    // Reset during T2 of an add aborts it with no done pulse
    @(negedge clock);
    run = 1'b1;
    din = {7'h0, OP_ADD, 3'd6, 3'd7};
    @(posedge clock);
    #1;
    run = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    @(negedge clock);
    checkOutput("abort pre done", {31'h0, done}, 32'h0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    @(negedge clock);
    checkOutput("abort done", {31'h0, done}, 32'h0);
    checkOutput("abort bus", {16'h0, bus}, 32'h0);
    checkRegs("abort");
    repeat (2) begin
      @(negedge clock);
      checkOutput("abort no pulse", {31'h0, done}, 32'h0);
    end
    applyStimulus(OP_MVI, 3'd2, 3'd0, 16'h00A5, 1, "post-reset mvi");

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
